reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 108 ++++++++++
 tb/tb_reg_file_sb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-ported register file with a per-register busy scoreboard.
// Two combinational read ports (A, B), two write ports (E, M; M wins on the
// same index) and one issue port that marks a destination as pending. Every
// write clears the busy bit of its destination, but an issue to the same
// register on the same edge keeps it set, because a newer producer is now
// outstanding. Optional write-to-read forwarding and a hard-wired zero register.
module reg_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] d_srcA,
   input  logic [ADDR_W-1:0] d_srcB,
   output logic [DATA_W-1:0] d_rvalA,
   output logic [DATA_W-1:0] d_rvalB,
   output logic              d_busyA,
   output logic              d_busyB,
   input  logic              W_enE,
   input  logic [ADDR_W-1:0] W_dstE,
   input  logic [DATA_W-1:0] W_valE,
   input  logic              W_enM,
   input  logic [ADDR_W-1:0] W_dstM,
   input  logic [DATA_W-1:0] W_valM,
   input  logic              i_en,
   input  logic [ADDR_W-1:0] i_dst
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regFileReg  [DEPTH];
   logic [DATA_W-1:0] regFileNext [DEPTH];
   logic [DEPTH-1:0]  busyReg;
   logic [DEPTH-1:0]  busyNext;

   // Per-register next state: M write overrides E write; an issue beats the
   // clear caused by a write. Register 0 is a constant when ZERO_REG is set.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
      if ((ZERO_REG != 0) && (gi == 0)) begin : gZero
         assign regFileNext[gi] = '0;
         assign busyNext[gi]    = 1'b0;
      end else begin : gNormal
         logic wrE;
         logic wrM;
         logic isIssued;
         assign wrE      = W_enE && (W_dstE == ADDR_W'(gi));
         assign wrM      = W_enM && (W_dstM == ADDR_W'(gi));
         assign isIssued = i_en  && (i_dst  == ADDR_W'(gi));
         assign regFileNext[gi] = wrM ? W_valM : (wrE ? W_valE : regFileReg[gi]);
         assign busyNext[gi]    = isIssued ? 1'b1 : ((wrE || wrM) ? 1'b0 : busyReg[gi]);
      end
   end

   // State register: asynchronous clear of all data and busy bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DEPTH; r++) begin
            regFileReg[r] <= '0;
         end
         busyReg <= '0;
      end else begin
         regFileReg <= regFileNext;
         busyReg    <= busyNext;
      end
   end

   // Read ports share one implementation; index 0 is port A, 1 is port B.
   logic [ADDR_W-1:0] srcIdx [2];
   logic [DATA_W-1:0] rdVal  [2];
   logic              rdBusy [2];

   assign srcIdx[0] = d_srcA;
   assign srcIdx[1] = d_srcB;

   for (genvar gi = 0; gi < 2; gi++) begin : gRead
      logic isZero;
      logic hitE;
      logic hitM;
      assign isZero = (ZERO_REG != 0) && (srcIdx[gi] == '0);
      assign hitE   = (BYPASS != 0) && W_enE && (W_dstE == srcIdx[gi]);
      assign hitM   = (BYPASS != 0) && W_enM && (W_dstM == srcIdx[gi]);

      // Forwarded data takes priority M, then E, then stored value; a
      // forwarded register is no longer waiting, so its busy reads as 0.
      always_comb begin
         rdVal[gi]  = regFileReg[srcIdx[gi]];
         rdBusy[gi] = busyReg[srcIdx[gi]];
         if (isZero) begin
            rdVal[gi]  = '0;
            rdBusy[gi] = 1'b0;
         end else if (hitM) begin
            rdVal[gi]  = W_valM;
            rdBusy[gi] = 1'b0;
         end else if (hitE) begin
            rdVal[gi]  = W_valE;
            rdBusy[gi] = 1'b0;
         end
      end
   end

   assign d_rvalA = rdVal[0];
   assign d_rvalB = rdVal[1];
   assign d_busyA = rdBusy[0];
   assign d_busyB = rdBusy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed test of reg_file_sb with default parameters
// (DATA_W=32, ADDR_W=5, ZERO_REG=1, BYPASS=1).
module tb_reg_file_sb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] d_srcA;
   logic [ADDR_W-1:0] d_srcB;
   logic [DATA_W-1:0] d_rvalA;
   logic [DATA_W-1:0] d_rvalB;
   logic              d_busyA;
   logic              d_busyB;
   logic              W_enE;
   logic [ADDR_W-1:0] W_dstE;
   logic [DATA_W-1:0] W_valE;
   logic              W_enM;
   logic [ADDR_W-1:0] W_dstM;
   logic [DATA_W-1:0] W_valM;
   logic              i_en;
   logic [ADDR_W-1:0] i_dst;

   int errors = 0;
   int checks = 0;

   reg_file_sb dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_srcA  (d_srcA),
      .d_srcB  (d_srcB),
      .d_rvalA (d_rvalA),
      .d_rvalB (d_rvalB),
      .d_busyA (d_busyA),
      .d_busyB (d_busyB),
      .W_enE   (W_enE),
      .W_dstE  (W_dstE),
      .W_valE  (W_valE),
      .W_enM   (W_enM),
      .W_dstM  (W_dstM),
      .W_valM  (W_valM),
      .i_en    (i_en),
      .i_dst   (i_dst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      W_enE = 1'b0; W_dstE = '0; W_valE = '0;
      W_enM = 1'b0; W_dstM = '0; W_valM = '0;
      i_en  = 1'b0; i_dst  = '0;
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      d_srcA = 5'd5; d_srcB = 5'd31;
      #2;
      checks++; if (d_rvalA !== 32'd0) begin errors++; $display("FAIL reset_rvalA actual=%0h required=0", d_rvalA); end
      checks++; if (d_rvalB !== 32'd0) begin errors++; $display("FAIL reset_rvalB actual=%0h required=0", d_rvalB); end
      checks++; if (d_busyA !== 1'b0) begin errors++; $display("FAIL reset_busyA actual=%b required=0", d_busyA); end
      checks++; if (d_busyB !== 1'b0) begin errors++; $display("FAIL reset_busyB actual=%b required=0", d_busyB); end
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset: rvalA=%0h rvalB=%0h busyA=%b busyB=%b", d_rvalA, d_rvalB, d_busyA, d_busyB);
   endtask

   task automatic test_basic_write();
      W_enE = 1'b1; W_dstE = 5'd1; W_valE = 32'd1;
      W_enM = 1'b1; W_dstM = 5'd2; W_valM = 32'd2;
      tick();
      idle();
      d_srcA = 5'd1; d_srcB = 5'd2;
      #1;
      checks++; if (d_rvalA !== 32'd1) begin errors++; $display("FAIL basic_rvalA actual=%0h required=1", d_rvalA); end
      checks++; if (d_rvalB !== 32'd2) begin errors++; $display("FAIL basic_rvalB actual=%0h required=2", d_rvalB); end
      checks++; if (d_busyA !== 1'b0) begin errors++; $display("FAIL basic_busyA actual=%b required=0", d_busyA); end
      checks++; if (d_busyB !== 1'b0) begin errors++; $display("FAIL basic_busyB actual=%b required=0", d_busyB); end
      $display("basic write: r1=%0h r2=%0h", d_rvalA, d_rvalB);
   endtask

   task automatic test_collision();
      W_enE = 1'b1; W_dstE = 5'd3; W_valE = 32'd3;
      W_enM = 1'b1; W_dstM = 5'd3; W_valM = 32'd4;
      d_srcA = 5'd3; d_srcB = 5'd2;
      #1;
      checks++; if (d_rvalA !== 32'd4) begin errors++; $display("FAIL collision_bypass actual=%0h required=4", d_rvalA); end
      checks++; if (d_rvalB !== 32'd2) begin errors++; $display("FAIL collision_other_port actual=%0h required=2", d_rvalB); end
      tick();
      idle();
      #1;
      checks++; if (d_rvalA !== 32'd4) begin errors++; $display("FAIL collision_stored actual=%0h required=4", d_rvalA); end
      // E-only forwarding on port B
      W_enE = 1'b1; W_dstE = 5'd6; W_valE = 32'h66;
      d_srcB = 5'd6;
      #1;
      checks++; if (d_rvalB !== 32'h66) begin errors++; $display("FAIL bypass_E actual=%0h required=66", d_rvalB); end
      tick();
      idle();
      $display("collision: r3=%0h", d_rvalA);
   endtask

   task automatic test_zero_reg();
      W_enE = 1'b1; W_dstE = 5'd0; W_valE = 32'd5;
      i_en = 1'b1; i_dst = 5'd0;
      d_srcA = 5'd0; d_srcB = 5'd0;
      #1;
      checks++; if (d_rvalA !== 32'd0) begin errors++; $display("FAIL zero_before actual=%0h required=0", d_rvalA); end
      tick();
      idle();
      #1;
      checks++; if (d_rvalB !== 32'd0) begin errors++; $display("FAIL zero_after actual=%0h required=0", d_rvalB); end
      checks++; if (d_busyA !== 1'b0) begin errors++; $display("FAIL zero_busy actual=%b required=0", d_busyA); end
      $display("zero reg: r0=%0h busy=%b", d_rvalB, d_busyA);
   endtask

   task automatic test_scoreboard();
      i_en = 1'b1; i_dst = 5'd7;
      tick();
      idle();
      d_srcA = 5'd7;
      #1;
      checks++; if (d_busyA !== 1'b1) begin errors++; $display("FAIL sb_issue_busy actual=%b required=1", d_busyA); end
      W_enE = 1'b1; W_dstE = 5'd7; W_valE = 32'd9;
      #1;
      checks++; if (d_rvalA !== 32'd9) begin errors++; $display("FAIL sb_fwd_val actual=%0h required=9", d_rvalA); end
      checks++; if (d_busyA !== 1'b0) begin errors++; $display("FAIL sb_fwd_busy actual=%b required=0", d_busyA); end
      tick();
      idle();
      #1;
      checks++; if (d_busyA !== 1'b0) begin errors++; $display("FAIL sb_cleared actual=%b required=0", d_busyA); end
      checks++; if (d_rvalA !== 32'd9) begin errors++; $display("FAIL sb_stored actual=%0h required=9", d_rvalA); end
      // Double issue then a single write clears
      i_en = 1'b1; i_dst = 5'd8;
      tick();
      tick();
      idle();
      d_srcB = 5'd8;
      #1;
      checks++; if (d_busyB !== 1'b1) begin errors++; $display("FAIL sb_double_issue actual=%b required=1", d_busyB); end
      W_enM = 1'b1; W_dstM = 5'd8; W_valM = 32'h88;
      tick();
      idle();
      #1;
      checks++; if (d_busyB !== 1'b0) begin errors++; $display("FAIL sb_single_clear actual=%b required=0", d_busyB); end
      $display("scoreboard: r7=%0h busy7=%b busy8=%b", d_rvalA, d_busyA, d_busyB);
   endtask

   task automatic test_issue_and_write();
      i_en = 1'b1; i_dst = 5'd5;
      W_enE = 1'b1; W_dstE = 5'd5; W_valE = 32'h55;
      tick();
      idle();
      d_srcA = 5'd5;
      #1;
      checks++; if (d_busyA !== 1'b1) begin errors++; $display("FAIL set_wins_busy actual=%b required=1", d_busyA); end
      checks++; if (d_rvalA !== 32'h55) begin errors++; $display("FAIL set_wins_data actual=%0h required=55", d_rvalA); end
      $display("issue+write: r5=%0h busy5=%b", d_rvalA, d_busyA);
   endtask

   task automatic test_back_to_back();
      W_enE = 1'b1; W_dstE = 5'd10; W_valE = 32'hA;
      tick();
      W_valE = 32'hB;
      W_enM = 1'b1; W_dstM = 5'd11; W_valM = 32'hC;
      tick();
      idle();
      d_srcA = 5'd10; d_srcB = 5'd11;
      #1;
      checks++; if (d_rvalA !== 32'hB) begin errors++; $display("FAIL b2b_r10 actual=%0h required=b", d_rvalA); end
      checks++; if (d_rvalB !== 32'hC) begin errors++; $display("FAIL b2b_r11 actual=%0h required=c", d_rvalB); end
      $display("back-to-back: r10=%0h r11=%0h", d_rvalA, d_rvalB);
   endtask

   task automatic test_async_reset();
      i_en = 1'b1; i_dst = 5'd4;
      tick();
      idle();
      d_srcA = 5'd1; d_srcB = 5'd4;
      #1;
      checks++; if (d_rvalA !== 32'd1) begin errors++; $display("FAIL ar_pre_r1 actual=%0h required=1", d_rvalA); end
      checks++; if (d_busyB !== 1'b1) begin errors++; $display("FAIL ar_pre_busy4 actual=%b required=1", d_busyB); end
      rst_n = 1'b0;
      #1;
      checks++; if (d_rvalA !== 32'd0) begin errors++; $display("FAIL ar_r1 actual=%0h required=0", d_rvalA); end
      checks++; if (d_busyB !== 1'b0) begin errors++; $display("FAIL ar_busy4 actual=%b required=0", d_busyB); end
      // Writes and issues presented during reset are discarded
      W_enE = 1'b1; W_dstE = 5'd1; W_valE = 32'h77;
      i_en = 1'b1; i_dst = 5'd1;
      tick();
      idle();
      #1;
      checks++; if (d_rvalA !== 32'd0) begin errors++; $display("FAIL ar_write_discarded actual=%0h required=0", d_rvalA); end
      @(negedge clk);
      rst_n = 1'b1;
      W_enE = 1'b1; W_dstE = 5'd1; W_valE = 32'h99;
      tick();
      idle();
      #1;
      checks++; if (d_rvalA !== 32'h99) begin errors++; $display("FAIL ar_resume actual=%0h required=99", d_rvalA); end
      $display("async reset: r1=%0h busy4=%b", d_rvalA, d_busyB);
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_collision();
      test_zero_reg();
      test_scoreboard();
      test_issue_and_write();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
